// File: rtl/pipe_scheduler.sv
// pipe_scheduler: consumes the LFSR gap row and manages up to four on-screen
// pipe slots. Each scroll tick retires pipes that have left the screen,
// shifts the rest one column left, scores pipes crossing the bird column and
// periodically spawns a new pipe at the right edge.
module pipe_scheduler #(
    parameter int SCREEN_W      = 32,
    parameter int SPAWN_SPACING = 8,
    parameter int BIRD_COL      = 5
) (
    input  logic        i_Clk,
    input  logic        i_Reset_n,
    input  logic        i_Game_Active,
    input  logic        i_Scroll_Tick,
    input  logic [4:0]  i_Gap_Row,
    output logic [3:0]  o_Pipe_Valid,
    output logic [23:0] o_Pipe_X,
    output logic [19:0] o_Pipe_Gap,
    output logic        o_Score_Pulse,
    output logic [7:0]  o_Score,
    output logic        o_Overflow
);

    localparam int NSLOT = 4;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [5:0] SPAWN_X    = 6'(SCREEN_W - 1);
    localparam logic [5:0] SPAWN_LAST = 6'(SPAWN_SPACING - 1);
    localparam logic [5:0] BIRD_X     = 6'(BIRD_COL);

    logic [0:0] state_reg, state_next;
    logic [3:0] valid_reg, valid_next;
    logic [5:0] x_reg   [NSLOT];
    logic [5:0] x_next  [NSLOT];
    logic [4:0] gap_reg [NSLOT];
    logic [4:0] gap_next[NSLOT];
    logic [5:0] cnt_reg, cnt_next;
    logic [7:0] score_reg, score_next;
    logic       pulse_reg, pulse_next;
    logic       ovf_reg, ovf_next;

    // Per-slot tick classification: retiring (at column 0), moving, passing.
    logic [3:0] retire_w;
    logic [3:0] move_w;
    logic [3:0] pass_w;
    logic [3:0] kept_w;
    logic [3:0] free_w;
    logic [3:0] sel_w;

    genvar gi;
    generate
        for (gi = 0; gi < NSLOT; gi++) begin : g_slot
            assign retire_w[gi] = valid_reg[gi] && (x_reg[gi] == 6'd0);
            assign move_w[gi]   = valid_reg[gi] && (x_reg[gi] != 6'd0);
            assign pass_w[gi]   = move_w[gi] && (x_reg[gi] == BIRD_X);
            assign o_Pipe_X[6*gi +: 6]   = x_reg[gi];
            assign o_Pipe_Gap[5*gi +: 5] = gap_reg[gi];
        end
    endgenerate

    // Slots freed by retirement are immediately available to this tick's spawn.
    assign kept_w = valid_reg & ~retire_w;
    assign free_w = ~kept_w;
    // Isolate the lowest set bit: lowest-index free slot as one-hot.
    assign sel_w  = free_w & (~free_w + 4'd1);

    logic       spawn_due;
    logic       spawn_ok;
    logic [2:0] pass_cnt;
    logic [4:0] gap_clamped;
    logic [8:0] score_sum;

    assign spawn_due = (cnt_reg == SPAWN_LAST);
    assign spawn_ok  = spawn_due && (free_w != 4'd0);
    assign gap_clamped = (i_Gap_Row < 5'd2)  ? 5'd2  :
                         (i_Gap_Row > 5'd19) ? 5'd19 : i_Gap_Row;
    assign score_sum = {1'b0, score_reg} + {6'd0, pass_cnt};

    // Count simultaneous passes on this tick.
    always_comb begin
        pass_cnt = 3'd0;
        for (int i = 0; i < NSLOT; i++) begin
            pass_cnt = pass_cnt + {2'd0, pass_w[i]};
        end
    end

    // Next-state logic for the game FSM and all slot/score state.
    always_comb begin
        state_next = state_reg;
        valid_next = valid_reg;
        cnt_next   = cnt_reg;
        score_next = score_reg;
        pulse_next = 1'b0;
        ovf_next   = ovf_reg;
        for (int i = 0; i < NSLOT; i++) begin
            x_next[i]   = x_reg[i];
            gap_next[i] = gap_reg[i];
        end

        case (state_reg)
            ST_IDLE: begin
                if (i_Game_Active) begin
                    state_next = ST_RUN;
                    valid_next = 4'd0;
                    score_next = 8'd0;
                    ovf_next   = 1'b0;
                    cnt_next   = SPAWN_LAST;
                    for (int i = 0; i < NSLOT; i++) begin
                        x_next[i]   = 6'd0;
                        gap_next[i] = 5'd0;
                    end
                end
            end
            default: begin
                if (!i_Game_Active) begin
                    state_next = ST_IDLE;
                    valid_next = 4'd0;
                    cnt_next   = 6'd0;
                    for (int i = 0; i < NSLOT; i++) begin
                        x_next[i]   = 6'd0;
                        gap_next[i] = 5'd0;
                    end
                end else if (i_Scroll_Tick) begin
                    // Retired slots keep stale X/gap; only valid drops.
                    valid_next = kept_w | (spawn_ok ? sel_w : 4'd0);
                    for (int i = 0; i < NSLOT; i++) begin
                        if (move_w[i]) begin
                            x_next[i] = x_reg[i] - 6'd1;
                        end
                        if (spawn_ok && sel_w[i]) begin
                            x_next[i]   = SPAWN_X;
                            gap_next[i] = gap_clamped;
                        end
                    end
                    score_next = score_sum[8] ? 8'hFF : score_sum[7:0];
                    pulse_next = (pass_cnt != 3'd0);
                    if (spawn_due) begin
                        cnt_next = 6'd0;
                        if (!spawn_ok) begin
                            ovf_next = 1'b1;
                        end
                    end else begin
                        cnt_next = cnt_reg + 6'd1;
                    end
                end
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_reg <= ST_IDLE;
            valid_reg <= 4'd0;
            cnt_reg   <= 6'd0;
            score_reg <= 8'd0;
            pulse_reg <= 1'b0;
            ovf_reg   <= 1'b0;
            for (int i = 0; i < NSLOT; i++) begin
                x_reg[i]   <= 6'd0;
                gap_reg[i] <= 5'd0;
            end
        end else begin
            state_reg <= state_next;
            valid_reg <= valid_next;
            cnt_reg   <= cnt_next;
            score_reg <= score_next;
            pulse_reg <= pulse_next;
            ovf_reg   <= ovf_next;
            for (int i = 0; i < NSLOT; i++) begin
                x_reg[i]   <= x_next[i];
                gap_reg[i] <= gap_next[i];
            end
        end
    end

    assign o_Pipe_Valid  = valid_reg;
    assign o_Score       = score_reg;
    assign o_Score_Pulse = pulse_reg;
    assign o_Overflow    = ovf_reg;

endmodule

// File: tb/tb_pipe_scheduler.sv
// Testbench for pipe_scheduler: two instances (default spacing and spacing 4)
// share stimulus; each is compared every cycle against a behavioural model
// of the pipe list, plus directed checks at known points of a scripted game.
module tb_pipe_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ga = 1'b0;
    logic        tick = 1'b0;
    logic [4:0]  gap = 5'd0;

    logic [3:0]  valid_a, valid_b;
    logic [23:0] x_a, x_b;
    logic [19:0] gap_a, gap_b;
    logic        pulse_a, pulse_b;
    logic [7:0]  score_a, score_b;
    logic        ovf_a, ovf_b;

    int tests = 0;
    int failed = 0;

    localparam int BIRD = 5;
    localparam int SPAWN_COL = 31;

    always #5 clk = ~clk;

    pipe_scheduler dut_a (
        .i_Clk(clk), .i_Reset_n(rst_n), .i_Game_Active(ga),
        .i_Scroll_Tick(tick), .i_Gap_Row(gap),
        .o_Pipe_Valid(valid_a), .o_Pipe_X(x_a), .o_Pipe_Gap(gap_a),
        .o_Score_Pulse(pulse_a), .o_Score(score_a), .o_Overflow(ovf_a)
    );

    pipe_scheduler #(.SCREEN_W(32), .SPAWN_SPACING(4), .BIRD_COL(5)) dut_b (
        .i_Clk(clk), .i_Reset_n(rst_n), .i_Game_Active(ga),
        .i_Scroll_Tick(tick), .i_Gap_Row(gap),
        .o_Pipe_Valid(valid_b), .o_Pipe_X(x_b), .o_Pipe_Gap(gap_b),
        .o_Score_Pulse(pulse_b), .o_Score(score_b), .o_Overflow(ovf_b)
    );

    // Reference model: a game flag, a tick counter and four pipe records.
    int       spacing[2] = '{8, 4};
    bit       m_run[2];
    int       m_cnt[2];
    int       m_score[2];
    bit       m_pulse[2];
    bit       m_ovf[2];
    bit [3:0] m_valid[2];
    int       m_x[2][4];
    int       m_gap[2][4];

    task automatic check_eq(input string tag, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_run[k] = 0; m_cnt[k] = 0; m_score[k] = 0;
            m_pulse[k] = 0; m_ovf[k] = 0; m_valid[k] = 4'd0;
        end
    endtask

    task automatic model_step(input int k);
        int passes;
        int slot;
        int g;
        m_pulse[k] = 0;
        if (!m_run[k]) begin
            if (ga) begin
                m_run[k] = 1; m_valid[k] = 4'd0; m_score[k] = 0;
                m_ovf[k] = 0; m_cnt[k] = spacing[k] - 1;
            end
        end else if (!ga) begin
            m_run[k] = 0; m_valid[k] = 4'd0; m_cnt[k] = 0;
        end else if (tick) begin
            passes = 0;
            for (int i = 0; i < 4; i++) begin
                if (m_valid[k][i]) begin
                    if (m_x[k][i] == 0) begin
                        m_valid[k][i] = 1'b0;
                    end else begin
                        if (m_x[k][i] == BIRD) passes++;
                        m_x[k][i] = m_x[k][i] - 1;
                    end
                end
            end
            m_score[k] = (m_score[k] + passes > 255) ? 255 : m_score[k] + passes;
            m_pulse[k] = (passes > 0);
            if (m_cnt[k] == spacing[k] - 1) begin
                m_cnt[k] = 0;
                slot = -1;
                for (int i = 0; i < 4; i++) begin
                    if (!m_valid[k][i] && slot < 0) slot = i;
                end
                if (slot >= 0) begin
                    g = int'(gap);
                    if (g < 2) g = 2;
                    if (g > 19) g = 19;
                    m_valid[k][slot] = 1'b1;
                    m_x[k][slot] = SPAWN_COL;
                    m_gap[k][slot] = g;
                end else begin
                    m_ovf[k] = 1;
                end
            end else begin
                m_cnt[k] = m_cnt[k] + 1;
            end
        end
    endtask

    task automatic compare_dut(input int k, input logic [3:0] v, input logic [23:0] xs,
                               input logic [19:0] gs, input logic p, input logic [7:0] s,
                               input logic o);
        check_eq($sformatf("d%0d_valid", k), int'(v), int'(m_valid[k]));
        for (int i = 0; i < 4; i++) begin
            if (m_valid[k][i]) begin
                check_eq($sformatf("d%0d_x%0d", k, i), int'(xs[6*i +: 6]), m_x[k][i]);
                check_eq($sformatf("d%0d_gap%0d", k, i), int'(gs[5*i +: 5]), m_gap[k][i]);
            end
        end
        check_eq($sformatf("d%0d_pulse", k), int'(p), int'(m_pulse[k]));
        check_eq($sformatf("d%0d_score", k), int'(s), m_score[k]);
        check_eq($sformatf("d%0d_ovf", k), int'(o), int'(m_ovf[k]));
    endtask

    task automatic compare_both();
        compare_dut(0, valid_a, x_a, gap_a, pulse_a, score_a, ovf_a);
        compare_dut(1, valid_b, x_b, gap_b, pulse_b, score_b, ovf_b);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_valid"}, int'(valid_a), 0);
        check_eq({tag, "_x"}, int'(x_a), 0);
        check_eq({tag, "_gap"}, int'(gap_a), 0);
        check_eq({tag, "_score"}, int'(score_a), 0);
        check_eq({tag, "_pulse"}, int'(pulse_a), 0);
        check_eq({tag, "_ovf"}, int'(ovf_a), 0);
        check_eq({tag, "_x_b"}, int'(x_b), 0);
        check_eq({tag, "_ovf_b"}, int'(ovf_b), 0);
    endtask

    // One clock: apply inputs, advance model on the edge, check 1 time unit later.
    task automatic cycle(input bit g, input bit t, input int gr);
        logic [4:0] gv;
        gv = 5'(gr);
        ga = g; tick = t; gap = gv;
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        compare_both();
    endtask

    // Assert reset between edges and check outputs clear without a clock edge.
    task automatic async_reset(input string tag);
        #3;
        rst_n = 1'b0;
        ga = 1'b0; tick = 1'b0;
        #1;
        model_reset();
        check_all_zero(tag);
        @(posedge clk); #1;
        compare_both();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #3;
        check_all_zero("por");
        @(negedge clk);
        rst_n = 1'b1;
        $display("[TB] reset checked");

        // Idle with ticks: nothing happens.
        for (int i = 0; i < 3; i++) cycle(0, 1, 7);

        // Entry cycle with a tick: tick ignored.
        cycle(1, 1, 7);
        check_eq("entry_tick_ignored", int'(valid_a), 0);
        cycle(1, 1, 7);
        check_eq("first_valid", int'(valid_a), 1);
        check_eq("first_x", int'(x_a[5:0]), 31);
        check_eq("first_gap", int'(gap_a[4:0]), 7);
        $display("[TB] first spawn done");

        for (int i = 0; i < 8; i++) cycle(1, 1, 1);
        check_eq("sp1_x1", int'(x_a[11:6]), 31);
        check_eq("sp1_gap1", int'(gap_a[9:5]), 2);
        check_eq("sp1_x0", int'(x_a[5:0]), 23);
        for (int i = 0; i < 8; i++) cycle(1, 1, 23);
        check_eq("sp2_x2", int'(x_a[17:12]), 31);
        check_eq("sp2_gap2", int'(gap_a[14:10]), 19);
        check_eq("sp2_x1", int'(x_a[11:6]), 23);
        check_eq("sp2_x0", int'(x_a[5:0]), 15);
        $display("[TB] spacing and clamp done");

        // Ticks 18..28: slot0 moves 5 -> 4 on tick 28.
        for (int i = 0; i < 11; i++) cycle(1, 1, $urandom_range(0, 31));
        check_eq("score_pulse", int'(pulse_a), 1);
        check_eq("score_one", int'(score_a), 1);
        cycle(1, 0, 0);
        check_eq("pulse_single", int'(pulse_a), 0);
        check_eq("score_hold", int'(score_a), 1);
        $display("[TB] first score done");

        // Ticks 29..33: slot0 retires and is respawned on tick 33.
        for (int i = 0; i < 5; i++) cycle(1, 1, $urandom_range(0, 31));
        check_eq("reuse_valid", int'(valid_a), 15);
        check_eq("reuse_x0", int'(x_a[5:0]), 31);
        check_eq("reuse_ovf", int'(ovf_a), 0);
        $display("[TB] retire+spawn done");

        // Long run to saturate the score; spacing-4 instance overflows.
        for (int i = 0; i < 2200; i++) cycle(1, 1, $urandom_range(0, 31));
        check_eq("score_sat", int'(score_a), 255);
        check_eq("no_ovf_default", int'(ovf_a), 0);
        check_eq("ovf_sticky_b", int'(ovf_b), 1);
        $display("[TB] saturation and overflow done");

        // Stop then restart.
        cycle(0, 1, 5);
        check_eq("stop_valid", int'(valid_a), 0);
        check_eq("stop_score_held", int'(score_a), 255);
        check_eq("stop_ovf_held_b", int'(ovf_b), 1);
        cycle(1, 0, 5);
        check_eq("restart_score", int'(score_a), 0);
        check_eq("restart_ovf_b", int'(ovf_b), 0);
        for (int i = 0; i < 20; i++) cycle(1, 1, $urandom_range(0, 31));
        check_eq("three_live", int'(valid_a), 7);
        $display("[TB] stop/start done");

        // Mid-game asynchronous reset, then stay idle until game active.
        async_reset("midreset");
        for (int i = 0; i < 3; i++) cycle(0, 1, 9);
        check_eq("post_reset_idle", int'(valid_a), 0);
        $display("[TB] mid-game reset done");

        // Randomized phase.
        ga = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            bit g;
            g = ga;
            if ($urandom_range(0, 199) == 0) g = ~g;
            if ($urandom_range(0, 1499) == 0) begin
                async_reset("rnd_reset");
            end else begin
                cycle(g, bit'($urandom_range(0, 1)), $urandom_range(0, 31));
            end
        end
        $display("[TB] random phase done");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/pipe_scheduler.md
# pipe_scheduler

Consumer side of the pipe random-gap source: samples the 5-bit gap row produced by the LFSR and uses it to spawn, scroll, retire and score pipes. It keeps up to four on-screen pipe slots, each holding an X column and a gap row. It advances all slots on each scroll tick and flags when a pipe passes the bird column. It sits between the random gap generator and the pipe renderer/collision logic.

## Interface
Parameters:
- SCREEN_W, 32: screen width in pipe columns; spawn column is SCREEN_W-1; legal range 2..63.
- SPAWN_SPACING, 8: scroll ticks between spawns; legal range 1..63.
- BIRD_COL, 5: column of the bird; scoring boundary; legal range 1..SCREEN_W-1.

Ports:
- i_Clk  in  1  system clock.
- i_Reset_n  in  1  asynchronous, active-low reset.
- i_Game_Active  in  1  high while a game is in progress.
- i_Scroll_Tick  in  1  one-cycle pulse; one column of scroll.
- i_Gap_Row  in  5  random gap row from the LFSR, nominally 2..19.
- o_Pipe_Valid  out  4  per-slot valid bits; bit k is slot k.
- o_Pipe_X  out  24  slot k X column in bits [6k+5:6k].
- o_Pipe_Gap  out  20  slot k gap row in bits [5k+4:5k].
- o_Score_Pulse  out  1  one-cycle pulse per pipe passing the bird.
- o_Score  out  8  pipes passed this game; saturates at 255.
- o_Overflow  out  1  sticky; a spawn was dropped because no slot was free.

## Operation
- States:
  - IDLE: reset state.
  - RUN: entered on the first cycle i_Game_Active=1 is seen in IDLE; exits to IDLE on the first cycle i_Game_Active=0 is seen.
- On every IDLE->RUN transition:
  - clear all slots and o_Overflow.
  - clear o_Score.
  - load the spawn counter with SPAWN_SPACING-1, so the first tick in RUN spawns.
- On every RUN->IDLE transition:
  - clear all slots and the spawn counter.
  - hold o_Score and o_Overflow.
- i_Scroll_Tick is ignored in IDLE.
- On i_Scroll_Tick in RUN, the following apply in this order within one update:
  1. Retire: each valid slot with X==0 becomes invalid; its X and gap keep their stale values.
  2. Move: every other valid slot gets X <= X-1.
  3. Score: each slot moving from X==BIRD_COL to BIRD_COL-1 counts as one pass. Passes are summed and added to o_Score with saturation at 255. o_Score_Pulse is asserted if the count is nonzero.
  4. Spawn: if the spawn counter == SPAWN_SPACING-1, the counter goes to 0 and a spawn is attempted; otherwise the counter increments.
- Spawn rules:
  - Target is the lowest-index slot that is free after step 1.
  - The slot gets X=SCREEN_W-1 and gap=i_Gap_Row, clamped to 2..19: values <2 become 2, values >19 become 19.
  - If no slot is free, the spawn is dropped and o_Overflow is set; the counter still resets.
- Simultaneous retire and spawn on one tick: the retired slot is reusable by that same spawn.
- A newly spawned slot is not moved or scored on its spawn tick.

## Timing
- All outputs are registered and update on the clock edge that samples i_Scroll_Tick, so they are visible the cycle after the tick.
- o_Score_Pulse is high for exactly one cycle per qualifying tick, never two cycles back-to-back from a single tick.
- Consecutive-cycle ticks are legal; each tick is processed fully.
- i_Game_Active edge and i_Scroll_Tick in the same cycle:
  - state transition wins.
  - the tick is ignored, including the first tick of RUN arriving on the entry cycle.
- Reset (asynchronous, any time, including mid-game) forces:
  - state IDLE; o_Pipe_Valid=0, o_Pipe_X=0, o_Pipe_Gap=0.
  - o_Score=0, o_Score_Pulse=0, o_Overflow=0; spawn counter 0.
- Reset release is synchronous to i_Clk; the first active edge after release may take the IDLE->RUN transition.
- Steady-state occupancy with defaults: 32/8 = 4 pipes.
  - Each spawn coincides with the oldest pipe retiring from X==0, so defaults never overflow.

## Test plan
- Reset mid-game: run 20 ticks, assert i_Reset_n=0 asynchronously -> all outputs zero immediately; after release, stays IDLE until i_Game_Active is sampled high.
- First spawn: raise i_Game_Active, then one tick later with i_Gap_Row=7 -> the next cycle shows o_Pipe_Valid=4'b0001, slot0 X=31, gap=7.
- Spacing and clamp: 8 more ticks with i_Gap_Row=1, then 8 more with i_Gap_Row=23:
  - slot1 is X=31, gap=2, with slot0 at X=23.
  - then slot2 is X=31, gap=19, with slot1 at X=23 and slot0 at X=15.
- Scoring: tick slot0 from X=5 to 4 -> o_Score_Pulse high exactly one cycle and o_Score increments by 1; also preset o_Score=255 via 255 passes and check it holds at 255.
- Retire+spawn / overflow:
  - Defaults, 40 ticks -> slot0 retires from X==0 and slot0 is reused on the same tick with X=31; o_Overflow stays 0.
  - SPAWN_SPACING=4 -> fifth spawn is dropped and o_Overflow=1 sticky.
- Game stop/start: drop i_Game_Active with 3 pipes live -> next cycle o_Pipe_Valid=0 and o_Score held; raise it again -> o_Score=0 and o_Overflow=0.
